// File: rtl/q_max_reader.sv
// Read-side max scan over the nine Q action RAMs: issues one read per action for a
// latched board state and returns the largest Q among empty cells and its action.
module q_max_reader (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        start,
  input  logic [17:0] state,
  output logic        busy,
  output logic        done,
  output logic [7:0]  max_q,
  output logic [3:0]  best_action,
  output logic        no_legal,
  output logic        rd_en,
  output logic [3:0]  rd_sel,
  output logic [17:0] rd_address,
  input  logic [7:0]  rd_data
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} fsm_e;

  fsm_e        fsm_q, fsm_d;
  logic [17:0] st_q, st_d;
  logic [3:0]  sel_q, sel_d;
  logic        ren_q, ren_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  max_q_q, max_q_d;
  logic [3:0]  best_q, best_d;
  logic        nolegal_q, nolegal_d;
  logic [7:0]  acc_q, acc_d;
  logic [3:0]  acc_act_q, acc_act_d;
  logic        acc_valid_q, acc_valid_d;
  logic        tag_valid_q, tag_valid_d;
  logic        tag_legal_q, tag_legal_d;
  logic [3:0]  tag_act_q, tag_act_d;
  logic        take;

  // Tag travels one cycle behind each read so it lines up with the registered rd_data.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    tag_valid_d = ren_q;
    tag_act_d   = sel_q;
    tag_legal_d = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (sel_q == 4'(i + 1)) tag_legal_d = (st_q[2*i +: 2] == 2'b00);
    end
  end

  // Ties keep the earlier action because only a strictly greater value replaces acc.
  assign take = tag_valid_q && tag_legal_q &&
                (!acc_valid_q || ($signed(rd_data) > $signed(acc_q)));

  always_comb begin
    fsm_d       = fsm_q;
    st_d        = st_q;
    sel_d       = sel_q;
    ren_d       = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    max_q_d     = max_q_q;
    best_d      = best_q;
    nolegal_d   = nolegal_q;
    acc_d       = take ? rd_data   : acc_q;
    acc_act_d   = take ? tag_act_q : acc_act_q;
    acc_valid_d = acc_valid_q | take;

    unique case (fsm_q)
      IDLE: begin
        if (start) begin
          fsm_d       = SCAN;
          st_d        = state;
          sel_d       = 4'd1;
          ren_d       = 1'b1;
          busy_d      = 1'b1;
          acc_valid_d = 1'b0;
        end
      end
      SCAN: begin
        if (sel_q == 4'd9) begin
          fsm_d = DRAIN;
        end else begin
          sel_d = sel_q + 4'd1;
          ren_d = 1'b1;
        end
      end
      DRAIN: begin
        // Result is taken from the next-state accumulator so the final datum is included.
        fsm_d  = DONE;
        done_d = 1'b1;
        busy_d = 1'b0;
        if (acc_valid_d) begin
          max_q_d   = acc_d;
          best_d    = acc_act_d;
          nolegal_d = 1'b0;
        end else begin
          max_q_d   = 8'd0;
          best_d    = 4'd0;
          nolegal_d = 1'b1;
        end
      end
      DONE: fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      st_q        <= '0;
      sel_q       <= '0;
      ren_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      max_q_q     <= '0;
      best_q      <= '0;
      nolegal_q   <= 1'b0;
      acc_q       <= '0;
      acc_act_q   <= '0;
      acc_valid_q <= 1'b0;
      tag_valid_q <= 1'b0;
      tag_legal_q <= 1'b0;
      tag_act_q   <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values together.
      fsm_q       <= fsm_d;
      st_q        <= st_d;
      sel_q       <= sel_d;
      ren_q       <= ren_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      max_q_q     <= max_q_d;
      best_q      <= best_d;
      nolegal_q   <= nolegal_d;
      acc_q       <= acc_d;
      acc_act_q   <= acc_act_d;
      acc_valid_q <= acc_valid_d;
      tag_valid_q <= tag_valid_d;
      tag_legal_q <= tag_legal_d;
      tag_act_q   <= tag_act_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign max_q       = max_q_q;
  assign best_action = best_q;
  assign no_legal    = nolegal_q;
  assign rd_en       = ren_q;
  assign rd_sel      = sel_q;
  assign rd_address  = st_q;

endmodule

// File: tb/tb_q_max_reader.sv
// Directed bench for q_max_reader: behavioural RAM bank, reference max model and a
// scoreboard queue of expected results popped on each done pulse.
module tb_q_max_reader;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [17:0] state = '0;
  logic        busy, done, no_legal, rd_en;
  logic [7:0]  max_q;
  logic [3:0]  best_action, rd_sel;
  logic [17:0] rd_address;
  logic [7:0]  rd_data = '0;

  typedef struct packed {
    logic [7:0] mq;
    logic [3:0] act;
    logic       nl;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] q_mem [1:9];
  int         n_cmp = 0;
  int         n_err = 0;

  q_max_reader dut (
    .clock(clock), .rst_n(rst_n), .start(start), .state(state),
    .busy(busy), .done(done), .max_q(max_q), .best_action(best_action),
    .no_legal(no_legal), .rd_en(rd_en), .rd_sel(rd_sel),
    .rd_address(rd_address), .rd_data(rd_data)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (rd_en) rd_data <= q_mem[rd_sel];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [17:0] s);
    exp_t       e;
    logic       v;
    logic [7:0] best;
    logic [3:0] act;
    v = 1'b0; best = '0; act = '0;
    for (int a = 1; a <= 9; a++) begin
      if (s[2*(a-1) +: 2] == 2'b00 && (!v || $signed(q_mem[a]) > $signed(best))) begin
        v = 1'b1; best = q_mem[a]; act = 4'(a);
      end
    end
    e.mq  = v ? best : 8'd0;
    e.act = v ? act  : 4'd0;
    e.nl  = !v;
    return e;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_max_q"}, 32'(max_q), 0);
    check({tag, "_best"}, 32'(best_action), 0);
    check({tag, "_nolegal"}, 32'(no_legal), 0);
    check({tag, "_rd_en"}, 32'(rd_en), 0);
    check({tag, "_rd_sel"}, 32'(rd_sel), 0);
    check({tag, "_rd_addr"}, 32'(rd_address), 0);
  endtask

  // Starts a scan, checks the read protocol each cycle and the result on done.
  // Returns #1 after the edge that raises done.
  task automatic run_scan(input string tag, input logic [17:0] s, input bit disturb);
    exp_t e;
    int   lat;
    bit   seen;
    sb.push_back(model(s));
    @(posedge clock); #1;
    start = 1'b1; state = s;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      if (lat <= 8) begin
        check({tag, "_rd_en"}, 32'(rd_en), 1);
        check({tag, "_rd_sel"}, 32'(rd_sel), 32'(lat + 1));
        check({tag, "_rd_addr"}, 32'(rd_address), 32'(s));
        check({tag, "_busy"}, 32'(busy), 1);
      end else if (lat == 9) begin
        check({tag, "_rd_en_drain"}, 32'(rd_en), 0);
      end
      if (disturb && lat == 3) begin
        state = ~s; start = 1'b1;
      end
      if (disturb && lat == 4) start = 1'b0;
      if (done) seen = 1'b1;
      else begin
        @(posedge clock); #1;
        lat++;
      end
    end
    check({tag, "_latency"}, 32'(lat), 10);
    e = sb.pop_front();
    if (seen) begin
      check({tag, "_max_q"}, 32'(max_q), 32'(e.mq));
      check({tag, "_best"}, 32'(best_action), 32'(e.act));
      check({tag, "_nolegal"}, 32'(no_legal), 32'(e.nl));
    end
  endtask

  initial begin
    int          t1 [9] = '{5, -3, 12, 7, 12, 0, -128, 1, 9};
    logic [17:0] s2, s_full, s_one;

    s2 = '0; s_full = '0; s_one = '0;
    for (int i = 1; i <= 7; i++) s2[2*i +: 2] = 2'((i % 3) + 1);
    for (int i = 0; i < 9; i++) s_full[2*i +: 2] = (i % 2 == 0) ? 2'b01 : 2'b10;
    for (int i = 0; i < 9; i++) if (i != 6) s_one[2*i +: 2] = 2'b11;
    for (int i = 0; i < 9; i++) q_mem[i+1] = 8'(t1[i]);

    // Reset state
    #12;
    check_all_zero("reset");
    @(posedge clock); #3;
    rst_n = 1'b1;

    // Empty board, tie on 12 resolves to action 3; mid-scan state change and start ignored
    run_scan("t1", 18'd0, 1'b1);
    check("t1_max_const", 32'(max_q), 12);
    check("t1_best_const", 32'(best_action), 3);
    repeat (3) @(posedge clock);
    #1;
    check("t1_hold_max", 32'(max_q), 12);
    check("t1_hold_done", 32'(done), 0);
    check("t1_idle_busy", 32'(busy), 0);

    // Only cells 0 and 8 empty; occupied 127 entries must be ignored
    q_mem[1] = 8'(-10);
    for (int a = 2; a <= 8; a++) q_mem[a] = 8'd127;
    q_mem[9] = 8'hFE;
    run_scan("t2", s2, 1'b0);
    check("t2_max_const", 32'(max_q), 32'h0FE);
    check("t2_best_const", 32'(best_action), 9);

    // Full board
    run_scan("t3", s_full, 1'b0);
    check("t3_nolegal_const", 32'(no_legal), 1);

    // Reset mid-scan
    for (int i = 0; i < 9; i++) q_mem[i+1] = 8'(t1[i]);
    @(posedge clock); #1;
    start = 1'b1; state = 18'd0;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(posedge clock); #3;
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clock); #1;
      check("rst_no_done", 32'(done), 0);
    end
    run_scan("t4", 18'd0, 1'b0);
    check("t4_max_const", 32'(max_q), 12);

    // Back-to-back: second start in the cycle after done
    run_scan("b2b_a", 18'd0, 1'b0);
    run_scan("b2b_b", s_one, 1'b0);
    check("b2b_b_max_const", 32'(max_q), 32'h080);
    check("b2b_b_best_const", 32'(best_action), 7);

    // Start in the DONE cycle is ignored
    start = 1'b1; state = 18'd0;
    @(posedge clock); #1;
    start = 1'b0;
    check("done_start_rd_en", 32'(rd_en), 0);
    check("done_start_busy", 32'(busy), 0);
    repeat (2) begin
      @(posedge clock); #1;
      check("done_start_no_scan", 32'(rd_en), 0);
    end
    check("done_start_hold_max", 32'(max_q), 32'h080);
    check("done_start_hold_best", 32'(best_action), 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
